// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-stage stall/flush generation, shadow valid
// tracking, retire/cycle/stall performance counters and a mul/div hang watchdog.
module pipe_ctrl #(
  parameter int NSTAGES   = 5,
  parameter int ID_STAGE  = 1,
  parameter int EX_STAGE  = 2,
  parameter int CNT_W     = 64,
  parameter int MAX_STALL = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               fetch_valid_i,
  input  logic               branch_i,
  input  logic               load_use_i,
  input  logic               ex_busy_i,
  input  logic               exc_i,
  output logic [NSTAGES-1:0] stall_o,
  output logic [NSTAGES-1:0] flush_o,
  output logic [NSTAGES-1:0] valid_o,
  output logic [CNT_W-1:0]   nr_insts_o,
  output logic [CNT_W-1:0]   nr_cycles_o,
  output logic [CNT_W-1:0]   nr_stalls_o,
  output logic               hang_o
);

  localparam int RUN_W = $clog2(MAX_STALL + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);

  logic [NSTAGES-1:1] v_q;
  logic [NSTAGES-1:1] v_next;
  logic [RUN_W-1:0]   run_q;
  logic [RUN_W-1:0]   run_next;
  logic               retire;

  // Strict priority; masked lower-priority requests are simply dropped because
  // the requester's decode register is held and it will ask again.
  always_comb begin
    stall_o = '0;
    flush_o = '0;
    if (reset || exc_i) begin
      flush_o = '1;
    end else if (ex_busy_i) begin
      for (int k = 0; k <= EX_STAGE; k++) stall_o[k] = 1'b1;
      flush_o[EX_STAGE+1] = 1'b1;
    end else if (load_use_i) begin
      for (int k = 0; k <= ID_STAGE; k++) stall_o[k] = 1'b1;
      flush_o[ID_STAGE+1] = 1'b1;
    end else if (branch_i) begin
      flush_o[ID_STAGE] = 1'b1;
    end
  end

  assign valid_o = {v_q, fetch_valid_i};

  always_comb begin
    v_next = v_q;
    for (int k = 1; k < NSTAGES; k++) begin
      if (flush_o[k])      v_next[k] = 1'b0;
      else if (stall_o[k]) v_next[k] = v_q[k];
      else                 v_next[k] = valid_o[k-1];
    end
  end

  // An excepting instruction in the last stage is not counted as retired.
  assign retire = v_q[NSTAGES-1] & ~exc_i;

  always_comb begin
    run_next = '0;
    if (ex_busy_i && !exc_i) begin
      if (run_q == RUN_MAX) run_next = run_q;
      else                  run_next = run_q + RUN_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      v_q         <= '0;
      nr_insts_o  <= '0;
      nr_cycles_o <= '0;
      nr_stalls_o <= '0;
      run_q       <= '0;
      hang_o      <= 1'b0;
    end else begin
      v_q         <= v_next;
      nr_cycles_o <= nr_cycles_o + CNT_W'(1);
      if (retire)   nr_insts_o  <= nr_insts_o + CNT_W'(1);
      if (|stall_o) nr_stalls_o <= nr_stalls_o + CNT_W'(1);
      run_q <= run_next;
      // Sticky until reset.
      if (run_next == RUN_MAX) hang_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: default instance plus a MAX_STALL=4 instance
// sharing the same stimulus, checked against hand-computed values.
module tb_pipe_ctrl;

  logic        clock;
  logic        reset;
  logic        fetch_valid_i;
  logic        branch_i;
  logic        load_use_i;
  logic        ex_busy_i;
  logic        exc_i;
  logic [4:0]  stall_o, flush_o, valid_o;
  logic [63:0] nr_insts_o, nr_cycles_o, nr_stalls_o;
  logic        hang_o;
  logic [4:0]  stall2, flush2, valid2;
  logic [63:0] insts2, cycles2, stalls2;
  logic        hang2;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] base;

  pipe_ctrl dut (
    .clock(clock), .reset(reset), .fetch_valid_i(fetch_valid_i),
    .branch_i(branch_i), .load_use_i(load_use_i), .ex_busy_i(ex_busy_i),
    .exc_i(exc_i), .stall_o(stall_o), .flush_o(flush_o), .valid_o(valid_o),
    .nr_insts_o(nr_insts_o), .nr_cycles_o(nr_cycles_o),
    .nr_stalls_o(nr_stalls_o), .hang_o(hang_o)
  );

  pipe_ctrl #(.MAX_STALL(4)) dut4 (
    .clock(clock), .reset(reset), .fetch_valid_i(fetch_valid_i),
    .branch_i(branch_i), .load_use_i(load_use_i), .ex_busy_i(ex_busy_i),
    .exc_i(exc_i), .stall_o(stall2), .flush_o(flush2), .valid_o(valid2),
    .nr_insts_o(insts2), .nr_cycles_o(cycles2),
    .nr_stalls_o(stalls2), .hang_o(hang2)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic fv, input logic br, input logic lu,
                       input logic eb, input logic ex);
    fetch_valid_i = fv;
    branch_i      = br;
    load_use_i    = lu;
    ex_busy_i     = eb;
    exc_i         = ex;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick();
    tick();

    // Reset state
    check("rst_stall", 64'(stall_o), 64'h0);
    check("rst_flush", 64'(flush_o), 64'h1f);
    check("rst_valid", 64'(valid_o), 64'h0);
    check("rst_cycles", nr_cycles_o, 64'd0);
    check("rst_insts", nr_insts_o, 64'd0);
    check("rst_hang", 64'(hang_o), 64'd0);

    // Fill from reset: first retire at edge 5
    reset = 1'b0;
    drive(1, 0, 0, 0, 0);
    check("fill_stall", 64'(stall_o), 64'h0);
    check("fill_flush", 64'(flush_o), 64'h0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 4) check("fill_insts_e4", nr_insts_o, 64'd0);
      if (i == 5) check("fill_insts_e5", nr_insts_o, 64'd1);
    end
    check("fill_cycles", nr_cycles_o, 64'd10);
    check("fill_insts", nr_insts_o, 64'd6);
    check("fill_stalls", nr_stalls_o, 64'd0);
    check("fill_valid", 64'(valid_o), 64'h1f);

    // Load-use alone
    drive(1, 0, 1, 0, 0);
    check("lu_stall", 64'(stall_o), 64'h03);
    check("lu_flush", 64'(flush_o), 64'h04);
    tick();
    drive(1, 0, 0, 0, 0);
    check("lu_valid", 64'(valid_o), 64'h1b);
    check("lu_stalls", nr_stalls_o, 64'd1);

    // Branch alone
    drive(1, 1, 0, 0, 0);
    check("br_stall", 64'(stall_o), 64'h00);
    check("br_flush", 64'(flush_o), 64'h02);
    tick();
    drive(1, 0, 0, 0, 0);
    check("br_valid", 64'(valid_o), 64'h15);
    check("br_stalls", nr_stalls_o, 64'd1);

    // ex_busy with a masked branch for 3 cycles
    base = nr_stalls_o;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 1, 0);
      check("eb_stall", 64'(stall_o), 64'h07);
      check("eb_flush", 64'(flush_o), 64'h08);
      tick();
    end
    drive(1, 0, 0, 0, 0);
    check("eb_stalls", nr_stalls_o, base + 64'd3);
    check("eb_hang4", 64'(hang2), 64'd0);

    // Exception beats load-use; excepting instruction not retired
    for (int i = 0; i < 4; i++) tick();
    drive(0, 0, 0, 0, 0);
    check("exc_pre_valid", 64'(valid_o), 64'h1e);
    base = nr_insts_o;
    drive(0, 0, 1, 0, 1);
    check("exc_flush", 64'(flush_o), 64'h1f);
    check("exc_stall", 64'(stall_o), 64'h00);
    tick();
    drive(0, 0, 0, 0, 0);
    check("exc_insts", nr_insts_o, base);
    check("exc_valid", 64'(valid_o), 64'h00);

    // Watchdog on the MAX_STALL=4 instance
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) tick();
    check("hang_e3", 64'(hang2), 64'd0);
    tick();
    check("hang_e4", 64'(hang2), 64'd1);
    check("hang_dflt", 64'(hang_o), 64'd0);
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    check("hang_sticky", 64'(hang2), 64'd1);

    // exc with ex_busy: flush all, run counter cleared, hang kept
    drive(0, 0, 0, 1, 1);
    check("excb_flush", 64'(flush_o), 64'h1f);
    check("excb_stall", 64'(stall_o), 64'h00);
    tick();
    check("excb_hang", 64'(hang2), 64'd1);
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) tick();
    check("excb_stall_run", 64'(stall2), 64'h07);

    // Reset mid-stall abandons the stall and clears hang
    reset = 1'b1;
    drive(0, 0, 0, 1, 0);
    check("rst_mid_stall", 64'(stall_o), 64'h00);
    check("rst_mid_flush", 64'(flush_o), 64'h1f);
    tick();
    check("rst_hang_clr", 64'(hang2), 64'd0);
    check("rst_cyc_clr", nr_cycles_o, 64'd0);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    tick();
    check("post_rst_stall", 64'(stall_o), 64'h00);
    check("post_rst_cycles", nr_cycles_o, 64'd1);
    check("post_rst_stalls", nr_stalls_o, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high; the ports are named clock and reset.
REQ-002 Parameters (name, default, meaning) SHALL be:
- NSTAGES, 5, number of stall/flush bits; bit 0 = PC register, bit k = pipeline register k.
- ID_STAGE, 1, index of the register feeding decode.
- EX_STAGE, 2, index of the register feeding execute.
- CNT_W, 64, performance counter width.
- MAX_STALL, 64, consecutive ex_busy cycles that set hang_o.
REQ-003 Legal parameters SHALL satisfy 0 < ID_STAGE < EX_STAGE < NSTAGES-1 and MAX_STALL >= 1. Other values are unsupported.
REQ-004 Ports (name, direction, width, meaning) SHALL be:
- clock, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- fetch_valid_i, in, 1, fetch is presenting a real instruction this cycle.
- branch_i, in, 1, decode redirect (taken branch, jump or mret).
- load_use_i, in, 1, decode load-use hazard.
- ex_busy_i, in, 1, multi-cycle mul/div is not ready.
- exc_i, in, 1, exception in the last stage.
- stall_o, out, NSTAGES, per-stage hold.
- flush_o, out, NSTAGES, per-stage clear.
- valid_o, out, NSTAGES, shadow valid bits; bit 0 = fetch_valid_i.
- nr_insts_o, out, CNT_W, retired instruction count.
- nr_cycles_o, out, CNT_W, cycles since reset.
- nr_stalls_o, out, CNT_W, cycles with any stall_o bit set.
- hang_o, out, 1, sticky watchdog flag.

Function
REQ-005 stall_o and flush_o SHALL be combinational from the inputs, with this priority (highest first):
- exc_i: flush_o = all ones, stall_o = 0.
- ex_busy_i: stall_o bits [EX_STAGE:0] = 1; flush_o bit EX_STAGE+1 = 1 (bubble).
- load_use_i: stall_o bits [ID_STAGE:0] = 1; flush_o bit ID_STAGE+1 = 1.
- branch_i: flush_o bit ID_STAGE = 1; stall_o = 0.
- none: stall_o = 0, flush_o = 0.
REQ-006 A lower-priority request that is masked SHALL NOT be latched. The requester re-asserts it after the stall, because its decode register is held.
REQ-007 While reset = 1, stall_o SHALL be 0 and flush_o SHALL be all ones.
REQ-008 The shadow valid register v[k], for k = 1..NSTAGES-1, SHALL update on each rising clock edge, first matching rule wins:
- flush_o[k] = 1: v[k] <= 0.
- stall_o[k] = 1: v[k] holds.
- otherwise: v[k] <= v[k-1], where v[0] = fetch_valid_i.
REQ-009 A retire event SHALL occur in a cycle where v[NSTAGES-1] = 1 and exc_i = 0. Each retire event increments nr_insts_o on that edge. An instruction that raises an exception SHALL NOT be counted.
REQ-010 nr_cycles_o SHALL increment on every edge with reset = 0.
REQ-011 nr_stalls_o SHALL increment on every edge where stall_o != 0.
REQ-012 All counters SHALL wrap modulo 2^CNT_W without flagging.
REQ-013 The watchdog run counter SHALL have width $clog2(MAX_STALL+1) and behave as follows:
- Increments on each edge with ex_busy_i = 1 and exc_i = 0.
- Saturates at MAX_STALL.
- Clears to 0 on any edge where ex_busy_i = 0 or exc_i = 1.
REQ-014 hang_o SHALL set on the edge at which the run counter reaches MAX_STALL. It SHALL stay 1 until reset, regardless of later inputs.
REQ-015 exc_i together with ex_busy_i SHALL flush everything and clear the run counter. hang_o is not cleared by this.
REQ-016 The block SHALL contain no combinational path from any output back to any input.

Reset
REQ-017 On a clock edge with reset = 1, the following SHALL be forced to 0: v[NSTAGES-1:1], nr_insts_o, nr_cycles_o, nr_stalls_o, the run counter and hang_o.
REQ-018 Reset asserted mid-stall SHALL abandon the stall. One cycle after reset deasserts, with no hazard inputs, stall_o SHALL be 0.

Verification
REQ-019 The bench SHALL cover these directed scenarios, all with default parameters unless stated:
- load_use_i = 1 alone -> stall_o = 5'b00011, flush_o = 5'b00100; v[2] = 0 next cycle.
- branch_i = 1 alone -> stall_o = 0, flush_o = 5'b00010.
- ex_busy_i and branch_i together for 3 cycles -> stall_o = 5'b00111, flush_o = 5'b01000 in each cycle; nr_stalls_o increases by 3.
- exc_i with load_use_i and v = 5'b11110 -> flush_o = 5'b11111, stall_o = 0; nr_insts_o unchanged; v[4:1] = 0 next cycle.
- Reset released, fetch_valid_i = 1 held, no hazards, for 10 edges -> nr_cycles_o = 10, nr_insts_o = 6 (first increment at edge 5).
- MAX_STALL = 4, ex_busy_i = 1 for 4 edges -> hang_o = 1 after edge 4. Then ex_busy_i = 0 -> hang_o stays 1, and it clears only on reset.
